// File: rtl/sort_pkg.sv
// sort_pkg: shared state codes and widths for the manual-sort buffer controller
package sort_pkg;
   localparam int N_ENTRIES = 8;
   localparam int POS_W = 3;
   localparam int CNT_W = 5;
   localparam logic [CNT_W-1:0] CNT_MAX = 5'd31;
   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] SCAN = 3'd1;
   localparam logic [2:0] CHECK = 3'd2;
   localparam logic [2:0] SWAP = 3'd3;
   localparam logic [2:0] DONE = 3'd4;
endpackage

// File: rtl/pair_priority_enc.sv
// pair_priority_enc: lowest-index-first encode of adjacent out-of-order flags, 0 when none set
module pair_priority_enc
   import sort_pkg::*;
(
   input  logic [N_ENTRIES-2:0] gt,
   output logic [POS_W-1:0]     code
);
   always_comb
      code = gt[0] ? 3'd1 :
             gt[1] ? 3'd2 :
             gt[2] ? 3'd3 :
             gt[3] ? 3'd4 :
             gt[4] ? 3'd5 :
             gt[5] ? 3'd6 :
             gt[6] ? 3'd7 : 3'd0;
endmodule

// File: rtl/sort_controller.sv
// sort_controller: bubble-style sort of an 8-entry buffer, one swap of the first out-of-order pair per pass
module sort_controller
   import sort_pkg::*;
#(
   parameter int W = 4,
   parameter int N = N_ENTRIES
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load_en,
   input  logic [2:0]       load_idx,
   input  logic [W-1:0]     load_data,
   input  logic             start,
   input  logic [2:0]       rd_idx,
   output logic [W-1:0]     rd_data,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] swap_cnt,
   output logic [POS_W-1:0] pos
);
   logic [2:0]       state;
   logic [W-1:0]     mem [N];
   logic [N-2:0]     gt_reg;
   logic [POS_W-1:0] code;
   logic [POS_W-1:0] lo;
   pair_priority_enc u_enc (.gt(gt_reg), .code(code));
   assign lo = pos - POS_W'(1);
   assign rd_data = mem[rd_idx];
   assign busy = (state == SCAN) || (state == CHECK) || (state == SWAP);
   assign done = state == DONE;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         for (int i = 0; i < N; i++) mem[i] <= '0;
         gt_reg <= '0;
         pos <= '0;
         swap_cnt <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (load_en) mem[load_idx] <= load_data;
               if (start) begin
                  state <= SCAN;
                  swap_cnt <= '0;
               end
            end
            SCAN: begin
               for (int i = 0; i < N-1; i++) gt_reg[i] <= mem[i] > mem[i+1];
               state <= CHECK;
            end
            CHECK: begin
               pos <= code;
               state <= (code != '0) ? SWAP : DONE;
            end
            SWAP: begin
               mem[lo] <= mem[pos];
               mem[pos] <= mem[lo];
               swap_cnt <= (swap_cnt == CNT_MAX) ? swap_cnt : swap_cnt + CNT_W'(1);
               state <= SCAN;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/sort_controller.md
Name: sort_controller

Overview:
- Sequences an 8-entry manual-sort buffer using a first-out-of-order-pair priority encode, then swaps that pair.
- Repeats scan → encode → swap until the buffer is ascending (bubble-style, one swap per iteration).
- Sits between the front-panel load/start logic and the display read-out.
- Reports busy/done and the number of swaps performed.

Parameters:
- W, 4, data width of each buffer entry (unsigned).
- N, 8, number of entries; fixed at 8 (7 adjacent-pair flags, 3-bit position code); not to be overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- load_en  input  1  write load_data into entry load_idx; honoured only in IDLE or DONE.
- load_idx  input  3  entry index for load.
- load_data  input  W  value to load.
- start  input  1  begin sort; honoured only in IDLE or DONE.
- rd_idx  input  3  combinational read index.
- rd_data  output  W  buffer[rd_idx], combinational.
- busy  output  1  high in SCAN, CHECK, SWAP.
- done  output  1  high in DONE.
- swap_cnt  output  5  swaps performed in current/last sort, saturating at 31.
- pos  output  3  last latched position code (0 = sorted).

Behaviour:
- Reset (rst=1 at clk edge): state IDLE, all buffer entries 0, gt_reg 0, pos 0, swap_cnt 0, busy 0, done 0.
- Reset has priority over every other input. Reset mid-sort abandons the sort and clears the buffer.
- FSM states: IDLE, SCAN, CHECK, SWAP, DONE.
- IDLE:
  - load_en writes buffer[load_idx] <= load_data.
  - start → SCAN, and swap_cnt <= 0.
  - If load_en and start are asserted in the same cycle, the write happens and the sort uses the written value, because SCAN reads the buffer on the following cycle.
- SCAN (1 cycle): gt_reg[i] <= (buffer[i] > buffer[i+1]) for i = 0..6, unsigned compare. Equal entries are not out of order. Next state CHECK.
- CHECK (1 cycle): encode gt_reg with lowest index winning.
  - gt_reg[0] → code 1, gt_reg[1] → 2, … gt_reg[6] → 7; none set → 0.
  - pos <= code.
  - code ≠ 0 → SWAP; code = 0 → DONE.
- SWAP (1 cycle): exchange buffer[pos-1] and buffer[pos]; swap_cnt <= swap_cnt + 1, saturating at 31. Next state SCAN.
- DONE: done = 1 and buffer is stable.
  - load_en is honoured; done stays high.
  - start → SCAN with swap_cnt cleared, done drops next cycle.
- start and load_en in SCAN, CHECK or SWAP are ignored: no buffer change, no restart.
- Latency from the start-accept edge:
  - done rises 3 cycles later for already-sorted data.
  - Each swap adds 3 cycles: total = 3 + 3·swaps.
  - Worst case (reverse order) is 28 swaps = 87 cycles. Saturation of swap_cnt is therefore never reached in normal operation but is still required.
- rd_data is purely combinational at all times, including during a sort, and shows intermediate contents.

Decomposition:
- Shared package sort_pkg:
  - state enum: IDLE, SCAN, CHECK, SWAP, DONE.
  - constants: N_ENTRIES = 8, POS_W = 3, CNT_W = 5, CNT_MAX = 31.
- One natural sub-module, pair_priority_enc:
  - purely combinational 7-bit to 3-bit lowest-index-first encoder.
  - used in CHECK.
- The FSM, buffer and counter stay in sort_controller.

Test Plan:
- Reset values: assert rst mid-idle with a loaded buffer → next cycle every rd_data = 0, busy = 0, done = 0, swap_cnt = 0, pos = 0.
- Already sorted: load 0..7, pulse start → done at +3 cycles, swap_cnt = 0, pos = 0, contents unchanged.
- Single swap and encoder priority:
  - Load {0,1,2,3,5,4,6,7}, start → after first CHECK, pos = 5 (only gt_reg[4] set).
  - done at +6, swap_cnt = 1, buffer = 0..7.
- Reverse order (worst case): load 7..0, start → done at +87, swap_cnt = 28, buffer = 0..7, busy high every cycle until DONE.
- Duplicates and mid-sort stimulus:
  - Load {3,3,1,1,2,2,0,0}, start, then drive load_en = 1 (idx 0, data 9) and start = 1 during SWAP → both ignored.
  - Final buffer = {0,0,1,1,2,2,3,3}.
- Reset mid-sort and same-cycle load+start:
  - Assert rst in SWAP → IDLE, buffer cleared, done = 0.
  - Then in IDLE assert load_en (idx 7, data 0) together with start on a buffer of 1s → sort sees the 0; final buffer[0] = 0, swap_cnt = 7.
